quadrature_generator: RTL and testbench

QUADRATURE_GENERATOR -- requirements
Module: quadrature_generator

---
 rtl/quadrature_generator.sv | 157 +++++++++++++++
 tb/tb_quadrature_generator.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/quadrature_generator.sv
// Quadrature step generator: continuous (RUN) or counted (BURST) A/B phase stepping with a modulo-CPR position.
// Optional index pulse on each step that lands on pos 0, built only when QUAD_INDEX_EN is defined.
module quadrature_generator #(
  parameter int DIV_W  = 16,
  parameter int STEP_W = 16,
  parameter int CPR    = 1024,
  parameter int POS_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              start,
  input  logic [STEP_W-1:0] steps,
  input  logic              dir,
  input  logic [DIV_W-1:0]  div,
  output logic              phs_0,
  output logic              phs_90,
  output logic [POS_W-1:0]  pos,
  output logic              idx,
  output logic              busy,
  output logic              done,
  output logic [1:0]        state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_BURST = 2'd2
  } state_t;

  localparam logic [POS_W-1:0] POS_MAX = POS_W'(CPR - 1);

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [DIV_W-1:0]    presc_q, presc_d;
  logic                dir_q, dir_d;
  logic [STEP_W-1:0]   rem_q, rem_d;
  logic                phs0_q, phs0_d;
  logic                phs90_q, phs90_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic                done_q, done_d;
  logic                step;
  logic [POS_W-1:0]    pos_step;
  logic                phs0_step, phs90_step;
  logic                at_period;

  // Gray stepping: forward toggles phs_0 when the phases agree, phs_90 otherwise; reverse swaps the roles.
  always_comb begin
    phs0_step  = phs0_q;
    phs90_step = phs90_q;
    if ((phs0_q == phs90_q) ^ dir_q) phs0_step  = ~phs0_q;
    else                             phs90_step = ~phs90_q;
    if (!dir_q) pos_step = (pos_q == POS_MAX) ? '0 : pos_q + POS_W'(1);
    else        pos_step = (pos_q == '0) ? POS_MAX : pos_q - POS_W'(1);
  end

  assign at_period = (presc_q == div_q);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    presc_d = presc_q;
    dir_d   = dir_q;
    rem_d   = rem_q;
    phs0_d  = phs0_q;
    phs90_d = phs90_q;
    pos_d   = pos_q;
    done_d  = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start || run) begin
          state_d = start ? S_BURST : S_RUN;
          dir_d   = dir;
          div_d   = div;
          presc_d = '0;
          if (start) rem_d = steps;
        end
      end
      S_RUN: begin
        if (!run) begin
          state_d = S_IDLE;
        end else if (at_period) begin
          step    = 1'b1;
          presc_d = '0;
        end else begin
          presc_d = presc_q + DIV_W'(1);
        end
      end
      S_BURST: begin
        if (rem_q == '0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (at_period) begin
          step    = 1'b1;
          presc_d = '0;
          rem_d   = rem_q - STEP_W'(1);
          if (rem_q == STEP_W'(1)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end else begin
          presc_d = presc_q + DIV_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (step) begin
      phs0_d  = phs0_step;
      phs90_d = phs90_step;
      pos_d   = pos_step;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      presc_q <= '0;
      dir_q   <= 1'b0;
      rem_q   <= '0;
      phs0_q  <= 1'b0;
      phs90_q <= 1'b0;
      pos_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      presc_q <= presc_d;
      dir_q   <= dir_d;
      rem_q   <= rem_d;
      phs0_q  <= phs0_d;
      phs90_q <= phs90_d;
      pos_q   <= pos_d;
      done_q  <= done_d;
    end
  end

`ifdef QUAD_INDEX_EN
  logic idx_q;
  always_ff @(posedge clk) begin
    if (rst) idx_q <= 1'b0;
    else     idx_q <= step && (pos_step == '0);
  end
  assign idx = idx_q;
`else
  assign idx = 1'b0;
`endif

  assign phs_0   = phs0_q;
  assign phs_90  = phs90_q;
  assign pos     = pos_q;
  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_quadrature_generator.sv
// Directed bench for quadrature_generator: default instance (CPR=1024) plus a CPR=4 instance for index wrap.
module tb_quadrature_generator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        start = 1'b0;
  logic [15:0] steps = '0;
  logic        dir = 1'b0;
  logic [15:0] div = '0;

  logic        phs_0, phs_90, idx, busy, done;
  logic [15:0] pos;
  logic [1:0]  state_dbg;

  logic        q4_phs_0, q4_phs_90, q4_idx, q4_busy, q4_done;
  logic [1:0]  q4_pos;
  logic [1:0]  q4_state_dbg;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [1:0] fwd_seq [0:3] = '{2'b10, 2'b11, 2'b01, 2'b00};
  logic [1:0] rev_seq [0:4] = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b01};
  logic [1:0] exp_ph;
  logic       exp_idx;

  always #5 clk = ~clk;

  quadrature_generator u_dut (
    .clk(clk), .rst(rst), .run(run), .start(start), .steps(steps), .dir(dir), .div(div),
    .phs_0(phs_0), .phs_90(phs_90), .pos(pos), .idx(idx), .busy(busy), .done(done),
    .state_o(state_dbg)
  );

  quadrature_generator #(.CPR(4), .POS_W(2)) u_dut4 (
    .clk(clk), .rst(rst), .run(run), .start(start), .steps(steps), .dir(dir), .div(div),
    .phs_0(q4_phs_0), .phs_90(q4_phs_90), .pos(q4_pos), .idx(q4_idx), .busy(q4_busy),
    .done(q4_done), .state_o(q4_state_dbg)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt = total_cnt + 1;
    assert (obs === exp) pass_cnt = pass_cnt + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_phs",   {30'd0, phs_0, phs_90}, 32'h0);
    check("rst_pos",   32'(pos), 32'd0);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_done",  32'(done), 32'd0);
    check("rst_idx",   32'(idx), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);

    // Continuous forward run, div=0
    div = 16'd0; dir = 1'b0; run = 1'b1;
    tick();
    check("run_entry_busy", 32'(busy), 32'd1);
    check("run_entry_pos",  32'(pos), 32'd0);
    for (int i = 1; i <= 8; i++) begin
      tick();
      exp_ph = fwd_seq[(i - 1) % 4];
      check("run_phs",  {30'd0, phs_0, phs_90}, 32'(exp_ph));
      check("run_pos",  32'(pos), 32'(i));
      check("run_busy", 32'(busy), 32'd1);
    end
    run = 1'b0;
    tick();
    check("run_stop_busy", 32'(busy), 32'd0);
    check("run_stop_pos",  32'(pos), 32'd8);
    tick();
    check("run_hold_pos", 32'(pos), 32'd8);
    check("run_hold_phs", {30'd0, phs_0, phs_90}, 32'h0);

    // Reverse burst of 5, div=3; dir/div/start changes while busy are ignored
    rst = 1'b1;
    tick();
    rst = 1'b0;
    div = 16'd3; dir = 1'b1; steps = 16'd5; start = 1'b1;
    tick();
    start = 1'b0; dir = 1'b0; div = 16'd0; steps = 16'd9;
    check("burst_entry_busy",  32'(busy), 32'd1);
    check("burst_entry_state", 32'(state_dbg), 32'd2);
    for (int k = 1; k <= 5; k++) begin
      if (k == 2) start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      check("burst_wait_pos", 32'(pos), (k == 1) ? 32'd0 : 32'(1024 - (k - 1)));
      tick();
      check("burst_phs", {30'd0, phs_0, phs_90}, 32'(rev_seq[k - 1]));
      check("burst_pos", 32'(pos), 32'(1024 - k));
      check("burst_done", 32'(done), (k == 5) ? 32'd1 : 32'd0);
      check("burst_busy", 32'(busy), (k == 5) ? 32'd0 : 32'd1);
    end
    tick();
    check("burst_done_clr", 32'(done), 32'd0);
    check("burst_end_pos",  32'(pos), 32'd1019);

    // Zero-step burst
    steps = 16'd0; start = 1'b1;
    tick();
    start = 1'b0;
    check("zero_busy", 32'(busy), 32'd1);
    check("zero_done_early", 32'(done), 32'd0);
    tick();
    check("zero_done", 32'(done), 32'd1);
    check("zero_busy_off", 32'(busy), 32'd0);
    check("zero_phs", {30'd0, phs_0, phs_90}, 32'h1);
    check("zero_pos", 32'(pos), 32'd1019);
    tick();
    check("zero_done_clr", 32'(done), 32'd0);

    // Reset aborts a burst on the edge of its 3rd step
    div = 16'd0; dir = 1'b0; steps = 16'd10; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("abort_pre_phs", {30'd0, phs_0, phs_90}, 32'h2);
    check("abort_pre_pos", 32'(pos), 32'd1021);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_phs",  {30'd0, phs_0, phs_90}, 32'h0);
    check("abort_pos",  32'(pos), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    tick();
    check("abort_no_done", 32'(done), 32'd0);

    // start and run together: burst wins, run ignored until it ends
    steps = 16'd2; start = 1'b1; run = 1'b1;
    tick();
    start = 1'b0;
    check("prio_state", 32'(state_dbg), 32'd2);
    tick();
    check("prio_pos1", 32'(pos), 32'd1);
    tick();
    run = 1'b0;
    check("prio_pos2", 32'(pos), 32'd2);
    check("prio_done", 32'(done), 32'd1);
    check("prio_busy", 32'(busy), 32'd0);
    tick();
    check("prio_idle", 32'(state_dbg), 32'd0);
    check("prio_done_clr", 32'(done), 32'd0);

    // Index pulses on the CPR=4 instance
    rst = 1'b1;
    tick();
    rst = 1'b0;
    div = 16'd0; dir = 1'b0; run = 1'b1;
    tick();
    check("idx_entry", 32'(q4_idx), 32'd0);
    for (int k = 1; k <= 9; k++) begin
      tick();
`ifdef QUAD_INDEX_EN
      exp_idx = (k == 4) || (k == 8);
`else
      exp_idx = 1'b0;
`endif
      check("idx4_pos", 32'(q4_pos), 32'(k % 4));
      check("idx4_pulse", 32'(q4_idx), 32'(exp_idx));
      check("idx_main", 32'(idx), 32'd0);
    end
    run = 1'b0;
    tick();
    check("idx4_after", 32'(q4_idx), 32'd0);
    check("idx4_hold", 32'(q4_pos), 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
